// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU register-file constants and address type
package cpu_pkg;

    localparam int DEFAULT_REGISTER_WIDTH      = 8;
    localparam int DEFAULT_NUMBER_OF_REGISTERS = 8;
    localparam int DEFAULT_ADDRESS_WIDTH       = $clog2(DEFAULT_NUMBER_OF_REGISTERS);

    // Register index as seen by the parser, issue logic and ALU.
    typedef logic [DEFAULT_ADDRESS_WIDTH-1:0] registerAddress_t;

endpackage

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - pending bits, issue acceptance, outstanding count and hazard flag
module reg_scoreboard
    import cpu_pkg::*;
#(
    parameter int NUMBER_OF_REGISTERS = DEFAULT_NUMBER_OF_REGISTERS,
    localparam int ADDRESS_WIDTH      = $clog2(NUMBER_OF_REGISTERS)
) (
    input  logic                           clock,
    input  logic                           isResetN,
    input  logic                           writeEnable,
    input  logic [ADDRESS_WIDTH-1:0]       writeAddress,
    input  logic                           issueEnable,
    input  logic [ADDRESS_WIDTH-1:0]       issueAddress,
    input  logic                           completeEnable,
    input  logic [ADDRESS_WIDTH-1:0]       completeAddress,
    output logic [NUMBER_OF_REGISTERS-1:0] pending,
    output logic                           issueReady,
    output logic                           writeAccepted,
    output logic                           completeValid,
    output logic [ADDRESS_WIDTH:0]         outstanding,
    output logic                           hazardError
);

    logic                           writeValid;
    logic                           issueValid;
    logic                           completeHit;
    logic                           issueAccepted;
    logic                           hazardEvent;
    logic [NUMBER_OF_REGISTERS-1:0] pendingNext;
    logic [ADDRESS_WIDTH:0]         outstandingNext;

    // Decide what this cycle's requests do; register 0 requests are inert.
    always_comb begin
        writeValid    = writeEnable && (writeAddress != '0);
        issueValid    = issueEnable && (issueAddress != '0);
        completeValid = completeEnable && (completeAddress != '0);
        completeHit   = completeValid && pending[completeAddress];

        // A register whose result returns this cycle is free to be re-issued.
        issueReady    = !pending[issueAddress]
                        || (completeEnable && (completeAddress == issueAddress));
        issueAccepted = issueValid && issueReady;

        // A single-cycle write may not clobber an in-flight or returning register.
        writeAccepted = writeValid && !pending[writeAddress]
                        && !(completeValid && (completeAddress == writeAddress));

        hazardEvent   = (writeValid && !writeAccepted)
                        || (issueValid && !issueReady)
                        || (completeValid && !pending[completeAddress]);

        // Clear before set so complete+issue on one register leaves it pending.
        pendingNext = pending;
        if (completeValid) begin
            pendingNext[completeAddress] = 1'b0;
        end
        if (issueAccepted) begin
            pendingNext[issueAddress] = 1'b1;
        end

        outstandingNext = outstanding
                          + {{ADDRESS_WIDTH{1'b0}}, issueAccepted}
                          - {{ADDRESS_WIDTH{1'b0}}, completeHit};
    end

    // Scoreboard state; reset discards every in-flight result.
    always_ff @(posedge clock or negedge isResetN) begin
        if (!isResetN) begin
            pending     <= '0;
            outstanding <= '0;
            hazardError <= 1'b0;
        end else begin
            pending     <= pendingNext;
            outstanding <= outstandingNext;
            if (hazardEvent) begin
                hazardError <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/register_file_sb.sv
// rtl/register_file_sb.sv - multi-port register file with pending scoreboard and bypass
module register_file_sb
    import cpu_pkg::*;
#(
    parameter int REGISTER_WIDTH      = DEFAULT_REGISTER_WIDTH,
    parameter int NUMBER_OF_REGISTERS = DEFAULT_NUMBER_OF_REGISTERS,
    parameter int READ_PORTS          = 2,
    parameter int BYPASS              = 1,
    localparam int ADDRESS_WIDTH      = $clog2(NUMBER_OF_REGISTERS)
) (
    input  logic                                 clock,
    input  logic                                 isResetN,
    input  logic [READ_PORTS*ADDRESS_WIDTH-1:0]  readAddress,
    output logic [READ_PORTS*REGISTER_WIDTH-1:0] readData,
    output logic [READ_PORTS-1:0]                readBusy,
    input  logic                                 writeEnable,
    input  logic [ADDRESS_WIDTH-1:0]             writeAddress,
    input  logic [REGISTER_WIDTH-1:0]            writeValue,
    input  logic                                 issueEnable,
    input  logic [ADDRESS_WIDTH-1:0]             issueAddress,
    output logic                                 issueReady,
    input  logic                                 completeEnable,
    input  logic [ADDRESS_WIDTH-1:0]             completeAddress,
    input  logic [REGISTER_WIDTH-1:0]            completeValue,
    output logic [ADDRESS_WIDTH:0]               outstanding,
    output logic                                 hazardError
);

    logic [REGISTER_WIDTH-1:0]      registers [NUMBER_OF_REGISTERS];
    logic [NUMBER_OF_REGISTERS-1:0] pending;
    logic                           writeAccepted;
    logic                           completeValid;

    reg_scoreboard #(
        .NUMBER_OF_REGISTERS(NUMBER_OF_REGISTERS)
    ) scoreboard (
        .clock          (clock),
        .isResetN       (isResetN),
        .writeEnable    (writeEnable),
        .writeAddress   (writeAddress),
        .issueEnable    (issueEnable),
        .issueAddress   (issueAddress),
        .completeEnable (completeEnable),
        .completeAddress(completeAddress),
        .pending        (pending),
        .issueReady     (issueReady),
        .writeAccepted  (writeAccepted),
        .completeValid  (completeValid),
        .outstanding    (outstanding),
        .hazardError    (hazardError)
    );

    // Data array; completions always land, accepted writes never share their address.
    always_ff @(posedge clock or negedge isResetN) begin
        if (!isResetN) begin
            for (int i = 0; i < NUMBER_OF_REGISTERS; i++) begin
                registers[i] <= '0;
            end
        end else begin
            if (completeValid) begin
                registers[completeAddress] <= completeValue;
            end
            if (writeAccepted) begin
                registers[writeAddress] <= writeValue;
            end
        end
    end

    for (genvar k = 0; k < READ_PORTS; k++) begin : gReadPort
        logic [ADDRESS_WIDTH-1:0] portAddress;
        logic                     isZero;

        assign portAddress = readAddress[k*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        assign isZero      = (portAddress == '0);

        if (BYPASS != 0) begin : gBypass
            logic completing;
            logic writing;

            // A returning result outranks a same-cycle write, which outranks storage.
            assign completing = completeValid && (completeAddress == portAddress);
            assign writing    = writeAccepted && (writeAddress == portAddress);

            assign readData[k*REGISTER_WIDTH +: REGISTER_WIDTH] =
                isZero     ? '0 :
                completing ? completeValue :
                writing    ? writeValue :
                             registers[portAddress];
            assign readBusy[k] = !isZero && pending[portAddress] && !completing;
        end else begin : gStored
            assign readData[k*REGISTER_WIDTH +: REGISTER_WIDTH] =
                isZero ? '0 : registers[portAddress];
            assign readBusy[k] = !isZero && pending[portAddress];
        end
    end

endmodule

// File: tb/tb_register_file_sb.sv
// tb/tb_register_file_sb.sv - randomized and directed bench for register_file_sb
module tb_register_file_sb;

    localparam int W  = 8;
    localparam int N  = 8;
    localparam int R  = 2;
    localparam int AW = 3;

    logic            clock = 1'b0;
    logic            isResetN;
    logic [R*AW-1:0] readAddress;
    logic [R*W-1:0]  readData;
    logic [R-1:0]    readBusy;
    logic            writeEnable;
    logic [AW-1:0]   writeAddress;
    logic [W-1:0]    writeValue;
    logic            issueEnable;
    logic [AW-1:0]   issueAddress;
    logic            issueReady;
    logic            completeEnable;
    logic [AW-1:0]   completeAddress;
    logic [W-1:0]    completeValue;
    logic [AW:0]     outstanding;
    logic            hazardError;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] modelRegs [N];
    bit           modelPend [N];
    bit           modelHazard;

    always #5 clock = ~clock;

    register_file_sb #(
        .REGISTER_WIDTH(W),
        .NUMBER_OF_REGISTERS(N),
        .READ_PORTS(R),
        .BYPASS(1)
    ) dut (
        .clock(clock),
        .isResetN(isResetN),
        .readAddress(readAddress),
        .readData(readData),
        .readBusy(readBusy),
        .writeEnable(writeEnable),
        .writeAddress(writeAddress),
        .writeValue(writeValue),
        .issueEnable(issueEnable),
        .issueAddress(issueAddress),
        .issueReady(issueReady),
        .completeEnable(completeEnable),
        .completeAddress(completeAddress),
        .completeValue(completeValue),
        .outstanding(outstanding),
        .hazardError(hazardError)
    );

    task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < N; i++) begin
            modelRegs[i] = '0;
            modelPend[i] = 1'b0;
        end
        modelHazard = 1'b0;
    endtask

    function automatic int modelOutstanding();
        int count = 0;
        for (int i = 0; i < N; i++) count += int'(modelPend[i]);
        return count;
    endfunction

    function automatic bit modelWriteOk();
        return writeEnable && (writeAddress != 0) && !modelPend[writeAddress]
               && !(completeEnable && (completeAddress == writeAddress));
    endfunction

    function automatic bit modelIssueReady();
        return !modelPend[issueAddress] || (completeEnable && (completeAddress == issueAddress));
    endfunction

    task automatic checkOutputs();
        bit wok = modelWriteOk();
        for (int k = 0; k < R; k++) begin
            int a = int'(readAddress[k*AW +: AW]);
            logic [W-1:0] expData;
            bit expBusy;
            if (a == 0) begin
                expData = '0;
                expBusy = 1'b0;
            end else begin
                bit completing = completeEnable && (int'(completeAddress) == a);
                if (completing)                                   expData = completeValue;
                else if (wok && (int'(writeAddress) == a))        expData = writeValue;
                else                                              expData = modelRegs[a];
                expBusy = modelPend[a] && !completing;
            end
            checkValue($sformatf("readData%0d_r%0d", k, a), 32'(readData[k*W +: W]), 32'(expData));
            checkValue($sformatf("readBusy%0d_r%0d", k, a), 32'(readBusy[k]), 32'(expBusy));
        end
        checkValue("issueReady", 32'(issueReady), 32'(modelIssueReady()));
        checkValue("outstanding", 32'(outstanding), 32'(modelOutstanding()));
        checkValue("hazardError", 32'(hazardError), 32'(modelHazard));
    endtask

    task automatic commitModel();
        bit wok = modelWriteOk();
        bit rdy = modelIssueReady();
        if ((writeEnable && writeAddress != 0 && !wok)
            || (issueEnable && issueAddress != 0 && !rdy)
            || (completeEnable && completeAddress != 0 && !modelPend[completeAddress]))
            modelHazard = 1'b1;
        if (completeEnable && completeAddress != 0) begin
            modelRegs[completeAddress] = completeValue;
            modelPend[completeAddress] = 1'b0;
        end
        if (wok) modelRegs[writeAddress] = writeValue;
        if (issueEnable && issueAddress != 0 && rdy) modelPend[issueAddress] = 1'b1;
    endtask

    task automatic setIdle();
        writeEnable     = 1'b0;
        writeAddress    = '0;
        writeValue      = '0;
        issueEnable     = 1'b0;
        issueAddress    = '0;
        completeEnable  = 1'b0;
        completeAddress = '0;
        completeValue   = '0;
    endtask

    task automatic setRead(input int a0, input int a1);
        readAddress = {AW'(a1), AW'(a0)};
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic step();
        #1;
        checkOutputs();
        @(posedge clock);
        commitModel();
        @(negedge clock);
    endtask

    task automatic doReset();
        isResetN = 1'b0;
        modelReset();
        repeat (2) @(negedge clock);
        isResetN = 1'b1;
    endtask

    initial begin
        isResetN = 1'b1;
        setIdle();
        setRead(0, 0);
        @(negedge clock);
        doReset();

        // Reset state across all non-zero addresses.
        for (int a = 1; a < N; a++) begin
            setRead(a, N - a);
            #1;
            checkValue("rst_data0", 32'(readData[W-1:0]), 32'h0);
            checkValue("rst_busy", 32'(readBusy), 32'h0);
            step();
        end

        // Write r3 with same-cycle bypass, then stored read on both ports.
        writeEnable = 1'b1; writeAddress = 3; writeValue = 8'h5A; setRead(3, 3);
        #1;
        checkValue("wr_bypass", 32'(readData[W-1:0]), 32'h5A);
        step();
        setIdle();
        #1;
        checkValue("wr_stored0", 32'(readData[W-1:0]), 32'h5A);
        checkValue("wr_stored1", 32'(readData[2*W-1:W]), 32'h5A);
        step();

        // Issue r4, wait, then complete with 8'h81.
        issueEnable = 1'b1; issueAddress = 4; setRead(4, 3);
        step();
        setIdle();
        repeat (3) begin
            #1;
            checkValue("mc_busy", 32'(readBusy[0]), 32'h1);
            checkValue("mc_outstanding", 32'(outstanding), 32'h1);
            step();
        end
        completeEnable = 1'b1; completeAddress = 4; completeValue = 8'h81;
        #1;
        checkValue("mc_complete_data", 32'(readData[W-1:0]), 32'h81);
        checkValue("mc_complete_busy", 32'(readBusy[0]), 32'h0);
        step();
        setIdle();
        #1;
        checkValue("mc_after_outstanding", 32'(outstanding), 32'h0);
        step();

        // WAW on pending r2: write dropped, hazard next cycle.
        issueEnable = 1'b1; issueAddress = 2; setRead(2, 4);
        step();
        setIdle();
        writeEnable = 1'b1; writeAddress = 2; writeValue = 8'hFF;
        #1;
        checkValue("waw_hazard_before", 32'(hazardError), 32'h0);
        step();
        setIdle();
        #1;
        checkValue("waw_hazard_after", 32'(hazardError), 32'h1);
        checkValue("waw_kept", 32'(readData[W-1:0]), 32'h0);
        step();
        completeEnable = 1'b1; completeAddress = 2; completeValue = 8'h12;
        step();

        // Complete and re-issue r5 in one cycle with r6 also pending.
        setIdle();
        issueEnable = 1'b1; issueAddress = 5; setRead(5, 6);
        step();
        issueAddress = 6;
        step();
        completeEnable = 1'b1; completeAddress = 5; completeValue = 8'h77; issueAddress = 5;
        #1;
        checkValue("reissue_ready", 32'(issueReady), 32'h1);
        step();
        setIdle();
        #1;
        checkValue("reissue_outstanding", 32'(outstanding), 32'h2);
        checkValue("reissue_busy", 32'(readBusy[0]), 32'h1);
        step();
        completeEnable = 1'b1; completeAddress = 5; completeValue = 8'h01;
        step();
        completeAddress = 6; completeValue = 8'h02;
        step();
        setIdle();

        // Register 0 is inert, then asynchronous reset with r1 pending.
        doReset();
        writeEnable = 1'b1; writeAddress = 3; writeValue = 8'hC3;
        step();
        setIdle();
        writeEnable = 1'b1; writeAddress = 0; writeValue = 8'h33; setRead(0, 3);
        step();
        setIdle();
        issueEnable = 1'b1; issueAddress = 0;
        step();
        setIdle();
        #1;
        checkValue("r0_data", 32'(readData[W-1:0]), 32'h0);
        checkValue("r0_outstanding", 32'(outstanding), 32'h0);
        checkValue("r0_hazard", 32'(hazardError), 32'h0);
        step();
        issueEnable = 1'b1; issueAddress = 1;
        step();
        step();
        setIdle();
        setRead(1, 3);
        #1;
        checkValue("pre_rst_hazard", 32'(hazardError), 32'h1);
        checkValue("pre_rst_data", 32'(readData[2*W-1:W]), 32'hC3);
        #1;
        isResetN = 1'b0;
        #1;
        checkValue("arst_busy", 32'(readBusy[0]), 32'h0);
        checkValue("arst_outstanding", 32'(outstanding), 32'h0);
        checkValue("arst_hazard", 32'(hazardError), 32'h0);
        checkValue("arst_data", 32'(readData[2*W-1:W]), 32'h0);
        modelReset();
        @(negedge clock);
        isResetN = 1'b1;

        // Randomized traffic against the model.
        for (int n = 0; n < 500; n++) begin
            writeEnable     = ($urandom_range(0, 99) < 40);
            writeAddress    = AW'($urandom_range(0, N - 1));
            writeValue      = W'($urandom);
            issueEnable     = ($urandom_range(0, 99) < 30);
            issueAddress    = AW'($urandom_range(0, N - 1));
            completeEnable  = ($urandom_range(0, 99) < 30);
            completeAddress = AW'($urandom_range(0, N - 1));
            completeValue   = W'($urandom);
            setRead(int'($urandom_range(0, N - 1)), int'($urandom_range(0, N - 1)));
            if (n % 100 == 99) begin
                setIdle();
                doReset();
            end else begin
                step();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
